stopwatch_ctrl: RTL



---
 rtl/stopwatch_pkg.sv | 24 ++
 rtl/stopwatch_ctrl_time_counter.sv | 72 +++++++
 rtl/stopwatch_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared state encoding, field widths and time record for the stopwatch controller.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } sw_state_e;

    localparam int CS_W  = 7;
    localparam int SEC_W = 6;
    localparam int MIN_W = 7;

    localparam logic [CS_W-1:0]  CS_MAX  = 7'd99;
    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

    typedef struct packed {
        logic [MIN_W-1:0] min;
        logic [SEC_W-1:0] sec;
        logic [CS_W-1:0]  cs;
    } sw_time_t;

endpackage

// File: rtl/stopwatch_ctrl_time_counter.sv
// Prescaler plus cascaded centisecond/second/minute counters with saturation at MAX_MIN:59.99.
module time_counter
    import stopwatch_pkg::*;
#(
    parameter int TICKS_PER_CS = 10,
    parameter int MAX_MIN      = 99
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     en,
    input  logic     clr,
    output sw_time_t cnt_o,
    output logic     overflow
);

    localparam int                PW      = (TICKS_PER_CS > 1) ? $clog2(TICKS_PER_CS) : 1;
    localparam logic [PW-1:0]     PRE_MAX = PW'(TICKS_PER_CS - 1);
    localparam logic [MIN_W-1:0]  MIN_TOP = MIN_W'(MAX_MIN);

    logic [PW-1:0] pre_q, pre_d;
    sw_time_t      cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          at_max;

    always_comb begin
        pre_d  = pre_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        at_max = (cnt_q.min == MIN_TOP) && (cnt_q.sec == SEC_MAX) && (cnt_q.cs == CS_MAX);
        if (clr) begin
            pre_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (en) begin
            // Any tick at the ceiling saturates: value and prescaler hold, flag sets.
            if (at_max) begin
                ovf_d = 1'b1;
            end else if (pre_q == PRE_MAX) begin
                pre_d = '0;
                if (cnt_q.cs != CS_MAX) begin
                    cnt_d.cs = cnt_q.cs + 7'd1;
                end else begin
                    cnt_d.cs = '0;
                    if (cnt_q.sec != SEC_MAX) begin
                        cnt_d.sec = cnt_q.sec + 6'd1;
                    end else begin
                        cnt_d.sec = '0;
                        cnt_d.min = cnt_q.min + 7'd1;
                    end
                end
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            pre_q <= pre_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: button edge detect, start/stop/lap/clear FSM, lap snapshot and
// registered display mux around the time counter.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICKS_PER_CS = 10,
    parameter int MAX_MIN      = 99
) (
    input  logic       clkin,
    input  logic       rst_n,
    input  logic       tick_ms,
    input  logic       btn_start_stop,
    input  logic       btn_lap,
    input  logic       btn_clear,
    output logic [6:0] disp_min,
    output logic [5:0] disp_sec,
    output logic [6:0] disp_cs,
    output logic       running,
    output logic       frozen,
    output logic       overflow,
    output logic [1:0] state
);

    sw_state_e state_q, state_d;
    sw_time_t  snap_q, snap_d;
    sw_time_t  disp_q, disp_d;
    sw_time_t  live;
    logic      ss_hist_q, lap_hist_q, clr_hist_q;
    logic      ss_ev, lap_ev, clr_ev;
    logic      cnt_en, cnt_clr;

    assign ss_ev  = btn_start_stop & ~ss_hist_q;
    assign lap_ev = btn_lap & ~lap_hist_q;
    assign clr_ev = btn_clear & ~clr_hist_q;

    // Counting follows the pre-edge state, so a stopping edge still counts its tick.
    assign cnt_en = tick_ms && ((state_q == ST_RUN) || (state_q == ST_LAP));

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        cnt_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ss_ev) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (ss_ev) begin
                    state_d = ST_PAUSE;
                end else if (lap_ev) begin
                    state_d = ST_LAP;
                    snap_d  = live;
                end
            end
            ST_LAP: begin
                if (ss_ev)       state_d = ST_PAUSE;
                else if (lap_ev) state_d = ST_RUN;
            end
            ST_PAUSE: begin
                if (clr_ev) begin
                    state_d = ST_IDLE;
                    cnt_clr = 1'b1;
                end else if (ss_ev) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        disp_d = (state_q == ST_LAP) ? snap_q : live;
    end

    time_counter #(
        .TICKS_PER_CS (TICKS_PER_CS),
        .MAX_MIN      (MAX_MIN)
    ) u_time_counter (
        .clk      (clkin),
        .rst_n    (rst_n),
        .en       (cnt_en),
        .clr      (cnt_clr),
        .cnt_o    (live),
        .overflow (overflow)
    );

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            snap_q     <= '0;
            disp_q     <= '0;
            ss_hist_q  <= 1'b0;
            lap_hist_q <= 1'b0;
            clr_hist_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            snap_q     <= snap_d;
            disp_q     <= disp_d;
            ss_hist_q  <= btn_start_stop;
            lap_hist_q <= btn_lap;
            clr_hist_q <= btn_clear;
        end
    end

    assign disp_min = disp_q.min;
    assign disp_sec = disp_q.sec;
    assign disp_cs  = disp_q.cs;
    assign running  = (state_q == ST_RUN) || (state_q == ST_LAP);
    assign frozen   = (state_q == ST_LAP);
    assign state    = state_q;

endmodule
